// File: rtl/vga_fill_engine_pkg.sv
// vga_fill_pkg: shared definitions for the rectangle fill engine.
// Holds register offsets, CTRL/STATUS bit positions, the FSM state type
// and the pixel word packer shared with the vga_avalon plot slave.
package vga_fill_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_P0     = 3'd1;
  localparam logic [2:0] REG_P1     = 3'd2;
  localparam logic [2:0] REG_COLOUR = 3'd3;
  localparam logic [2:0] REG_COUNT  = 3'd4;

  localparam int CTRL_START    = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_DONE_CLR = 2;
  localparam int CTRL_IRQ_EN   = 3;

  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERROR  = 2;
  localparam int STAT_IRQ_EN = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ABORT = 2'd2
  } fill_state_t;

  // Pixel word understood by vga_avalon: {0, y[6:0], x[7:0], 8'h00, colour}.
  function automatic logic [31:0] pack_pixel(input logic [7:0] x,
                                             input logic [6:0] y,
                                             input logic [7:0] colour);
    return {1'b0, y, x, 8'h00, colour};
  endfunction

endpackage

// File: rtl/vga_fill_engine_if.sv
// vga_fill_engine_if: Avalon-MM slave (register port) and master (pixel
// write port) signals of the fill engine.
//   slave modport  : the engine's view (registers in, pixel writes out)
//   master modport : the host/fabric view driving the engine
interface vga_fill_engine_if;
  logic [2:0]  address;
  logic        read;
  logic [31:0] readdata;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] master_address;
  logic        master_write;
  logic [31:0] master_writedata;
  logic        master_waitrequest;
  logic        irq;

  modport slave (
    input  address, read, write, writedata, master_waitrequest,
    output readdata, master_address, master_write, master_writedata, irq
  );

  modport master (
    output address, read, write, writedata, master_waitrequest,
    input  readdata, master_address, master_write, master_writedata, irq
  );
endinterface

// File: rtl/vga_rect_scan.sv
// vga_rect_scan: raster scan counters for an inclusive rectangle.
// Ports: clk, reset_n; load (x,y <= x0,y0); advance (step in row-major
// order); x0/y0/x1/y1 corners; x/y current pixel; last high on (x1,y1).
module vga_rect_scan #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y1,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           last
);

  logic [X_W-1:0] x_r;
  logic [Y_W-1:0] y_r;

  // Scan position: load to top-left, then walk rows left to right.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_r <= '0;
      y_r <= '0;
    end else if (load) begin
      x_r <= x0;
      y_r <= y0;
    end else if (advance) begin
      if (x_r == x1) begin
        x_r <= x0;
        y_r <= y_r + Y_W'(1);
      end else begin
        x_r <= x_r + X_W'(1);
      end
    end
  end

  assign x    = x_r;
  assign y    = y_r;
  assign last = (x_r == x1) && (y_r == y1);

endmodule

// File: rtl/vga_fill_engine.sv
// vga_fill_engine: fills an axis-aligned rectangle on the VGA framebuffer.
// Ports: clk, reset_n (async, active-low), bus (vga_fill_engine_if.slave):
//   slave side  address/read/readdata/write/writedata (readLatency 1)
//   master side master_address/master_write/master_writedata/
//               master_waitrequest (one pixel word per accepted transfer)
//   irq         level, done & irq_en
module vga_fill_engine
  import vga_fill_pkg::*;
#(
  parameter logic [31:0] PLOT_ADDR = 32'h0000_0000,
  parameter int          X_W       = 8,
  parameter int          Y_W       = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  vga_fill_engine_if.slave   bus
);

  fill_state_t    state_r, next_state_s;
  logic [X_W-1:0] x0_r, x1_r, scan_x_s;
  logic [Y_W-1:0] y0_r, y1_r, scan_y_s;
  logic [7:0]     colour_r;
  logic [15:0]    count_r;
  logic           done_r, error_r, irq_en_r;
  logic [31:0]    readdata_r, rd_mux_s;
  logic           busy_s, accept_s, last_s, rect_ok_s;
  logic           wr_ctrl_s, start_s, abort_s, clr_s;
  logic           load_s, advance_s, finish_s;
  logic           unused_s;

  assign busy_s    = (state_r != IDLE);
  assign accept_s  = busy_s && !bus.master_waitrequest;
  assign rect_ok_s = (x1_r >= x0_r) && (y1_r >= y0_r);
  assign wr_ctrl_s = bus.write && (bus.address == REG_CTRL);
  assign start_s   = wr_ctrl_s && bus.writedata[CTRL_START];
  assign abort_s   = wr_ctrl_s && bus.writedata[CTRL_ABORT];
  assign clr_s     = wr_ctrl_s && bus.writedata[CTRL_DONE_CLR];
  assign unused_s  = ^bus.writedata[31:8+Y_W];

  vga_rect_scan #(.X_W(X_W), .Y_W(Y_W)) u_scan (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_s),
    .advance (advance_s),
    .x0      (x0_r),
    .y0      (y0_r),
    .x1      (x1_r),
    .y1      (y1_r),
    .x       (scan_x_s),
    .y       (scan_y_s),
    .last    (last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next state and scan control; the word on the bus only changes on acceptance.
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    finish_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s && rect_ok_s) begin
          next_state_s = RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (accept_s) begin
          // An abort landing on an acceptance keeps that pixel and stops at once.
          if (last_s || abort_s) begin
            next_state_s = IDLE;
            finish_s     = 1'b1;
          end else begin
            advance_s    = 1'b1;
            next_state_s = RUN;
          end
        end else if (abort_s) begin
          next_state_s = ABORT;
        end else begin
          next_state_s = RUN;
        end
      end
      ABORT: begin
        if (accept_s) begin
          next_state_s = IDLE;
          finish_s     = 1'b1;
        end else begin
          next_state_s = ABORT;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Geometry and colour registers; frozen while a fill is running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_r     <= '0;
      y0_r     <= '0;
      x1_r     <= '0;
      y1_r     <= '0;
      colour_r <= 8'h00;
    end else if (bus.write && !busy_s) begin
      case (bus.address)
        REG_P0: begin
          x0_r <= bus.writedata[X_W-1:0];
          y0_r <= bus.writedata[8 +: Y_W];
        end
        REG_P1: begin
          x1_r <= bus.writedata[X_W-1:0];
          y1_r <= bus.writedata[8 +: Y_W];
        end
        REG_COLOUR: colour_r <= bus.writedata[7:0];
        default: begin
        end
      endcase
    end
  end

  // Control/status flags and accepted-pixel counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_r   <= 1'b0;
      error_r  <= 1'b0;
      irq_en_r <= 1'b0;
      count_r  <= 16'h0000;
    end else begin
      if (wr_ctrl_s) begin
        irq_en_r <= bus.writedata[CTRL_IRQ_EN];
      end
      // Start beats done-clear; both clear done when honoured in IDLE.
      if (finish_s) begin
        done_r <= 1'b1;
      end else if ((state_r == IDLE) && (start_s || clr_s)) begin
        done_r <= 1'b0;
      end
      if ((state_r == IDLE) && start_s) begin
        error_r <= !rect_ok_s;
      end
      if (load_s) begin
        count_r <= 16'h0000;
      end else if (accept_s) begin
        count_r <= count_r + 16'h0001;
      end
    end
  end

  // Read data multiplexer.
  always_comb begin
    rd_mux_s = 32'h0000_0000;
    case (bus.address)
      REG_CTRL:   rd_mux_s = {28'h000_0000, irq_en_r, error_r, done_r, busy_s};
      REG_P0:     rd_mux_s = (32'(y0_r) << 8) | 32'(x0_r);
      REG_P1:     rd_mux_s = (32'(y1_r) << 8) | 32'(x1_r);
      REG_COLOUR: rd_mux_s = {24'h00_0000, colour_r};
      REG_COUNT:  rd_mux_s = {16'h0000, count_r};
      default:    rd_mux_s = 32'h0000_0000;
    endcase
  end

  // Registered read data (one cycle read latency).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'h0000_0000;
    end else if (bus.read) begin
      readdata_r <= rd_mux_s;
    end
  end

  assign bus.readdata         = readdata_r;
  assign bus.master_address   = PLOT_ADDR;
  assign bus.master_write     = busy_s;
  assign bus.master_writedata = busy_s ? pack_pixel(8'(scan_x_s), 7'(scan_y_s), colour_r)
                                       : 32'h0000_0000;
  assign bus.irq              = done_r & irq_en_r;

endmodule

// File: tb/tb_vga_fill_engine.sv
// Directed self-checking bench for vga_fill_engine.
module tb_vga_fill_engine;
  import vga_fill_pkg::*;

  localparam logic [31:0] PA = 32'h0000_1000;

  logic clk;
  logic reset_n;
  int   total_cnt;
  int   pass_cnt;
  int   acc_cnt;
  int   acc_base;
  logic [31:0] rd;
  logic [31:0] exp_words [6];

  vga_fill_engine_if bif();

  vga_fill_engine #(.PLOT_ADDR(PA), .X_W(8), .Y_W(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && bif.master_write && !bif.master_waitrequest) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    bif.address = a; bif.writedata = d; bif.write = 1'b1;
    step();
    bif.write = 1'b0; bif.writedata = 32'h0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    bif.address = a; bif.read = 1'b1;
    step();
    bif.read = 1'b0;
    d = bif.readdata;
  endtask

  initial begin
    total_cnt = 0; pass_cnt = 0; acc_cnt = 0;
    reset_n = 1'b0;
    bif.address = 3'd0; bif.read = 1'b0; bif.write = 1'b0;
    bif.writedata = 32'h0; bif.master_waitrequest = 1'b0;
    exp_words[0] = 32'h0302_00A5; exp_words[1] = 32'h0303_00A5;
    exp_words[2] = 32'h0304_00A5; exp_words[3] = 32'h0402_00A5;
    exp_words[4] = 32'h0403_00A5; exp_words[5] = 32'h0404_00A5;

    // Reset state
    #3;
    check("rst_mw", {31'h0, bif.master_write}, 32'h0);
    check("rst_mwd", bif.master_writedata, 32'h0);
    check("rst_rd", bif.readdata, 32'h0);
    check("rst_irq", {31'h0, bif.irq}, 32'h0);
    check("rst_maddr", bif.master_address, PA);
    @(negedge clk); reset_n = 1'b1;
    step();
    reg_read(REG_CTRL, rd);
    check("rst_status", rd, 32'h0);

    // Basic 3x2 fill, no stalls
    reg_write(REG_P0, 32'h0000_0302);
    reg_write(REG_P1, 32'h0000_0404);
    reg_write(REG_COLOUR, 32'h0000_00A5);
    acc_base = acc_cnt;
    reg_write(REG_CTRL, 32'h0000_0009);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("fill_mw%0d", i), {31'h0, bif.master_write}, 32'h1);
      check($sformatf("fill_word%0d", i), bif.master_writedata, exp_words[i]);
      check("fill_maddr", bif.master_address, PA);
      step();
    end
    check("fill_mw_end", {31'h0, bif.master_write}, 32'h0);
    check("fill_irq", {31'h0, bif.irq}, 32'h1);
    check("fill_acc", 32'(acc_cnt - acc_base), 32'd6);
    reg_read(REG_CTRL, rd);
    check("fill_status", rd, 32'h0000_000A);
    reg_read(REG_COUNT, rd);
    check("fill_count", rd, 32'd6);
    reg_read(3'd5, rd);
    check("rd_off5", rd, 32'h0);

    // Done-clear, then same fill with a 3-cycle stall on pixel 2
    reg_write(REG_CTRL, 32'h0000_000C);
    check("clr_irq", {31'h0, bif.irq}, 32'h0);
    acc_base = acc_cnt;
    reg_write(REG_CTRL, 32'h0000_0009);
    check("stall_word0", bif.master_writedata, exp_words[0]);
    step();
    bif.master_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_hold_mw%0d", i), {31'h0, bif.master_write}, 32'h1);
      check($sformatf("stall_hold%0d", i), bif.master_writedata, exp_words[1]);
      step();
    end
    bif.master_waitrequest = 1'b0;
    for (int i = 1; i < 6; i++) begin
      check($sformatf("stall_word%0d", i), bif.master_writedata, exp_words[i]);
      step();
    end
    check("stall_mw_end", {31'h0, bif.master_write}, 32'h0);
    check("stall_acc", 32'(acc_cnt - acc_base), 32'd6);
    reg_read(REG_COUNT, rd);
    check("stall_count", rd, 32'd6);

    // Invalid rectangle: x1 < x0
    reg_write(REG_P0, 32'h0000_0005);
    reg_write(REG_P1, 32'h0000_0004);
    acc_base = acc_cnt;
    reg_write(REG_CTRL, 32'h0000_0009);
    check("err_mw", {31'h0, bif.master_write}, 32'h0);
    step(); step();
    check("err_acc", 32'(acc_cnt - acc_base), 32'd0);
    reg_read(REG_CTRL, rd);
    check("err_status", rd, 32'h0000_000C);
    check("err_irq", {31'h0, bif.irq}, 32'h0);

    // Full clear, abort after 10 acceptances with the 11th stalled
    reg_write(REG_P0, 32'h0000_0000);
    reg_write(REG_P1, 32'h0000_7FFF);
    acc_base = acc_cnt;
    reg_write(REG_CTRL, 32'h0000_0009);
    for (int i = 0; i < 10; i++) step();
    check("abt_word10", bif.master_writedata, 32'h000A_00A5);
    bif.master_waitrequest = 1'b1;
    reg_write(REG_CTRL, 32'h0000_000A);
    check("abt_hold_mw", {31'h0, bif.master_write}, 32'h1);
    check("abt_hold_word", bif.master_writedata, 32'h000A_00A5);
    step();
    check("abt_hold_word2", bif.master_writedata, 32'h000A_00A5);
    bif.master_waitrequest = 1'b0;
    step();
    check("abt_mw_end", {31'h0, bif.master_write}, 32'h0);
    check("abt_acc", 32'(acc_cnt - acc_base), 32'd11);
    reg_read(REG_COUNT, rd);
    check("abt_count", rd, 32'd11);
    reg_read(REG_CTRL, rd);
    check("abt_status", rd, 32'h0000_000A);

    // Writes while busy are ignored; reset mid-fill
    reg_write(REG_CTRL, 32'h0000_000C);
    reg_write(REG_CTRL, 32'h0000_0009);
    step(); step(); step();
    reg_write(REG_P1, 32'h0000_0101);
    reg_write(REG_CTRL, 32'h0000_0009);
    check("busy_mw", {31'h0, bif.master_write}, 32'h1);
    check("busy_word", bif.master_writedata, 32'h0005_00A5);
    step();
    check("busy_word_next", bif.master_writedata, 32'h0006_00A5);
    reset_n = 1'b0;
    #1;
    check("mid_rst_mw", {31'h0, bif.master_write}, 32'h0);
    check("mid_rst_rd", bif.readdata, 32'h0);
    @(negedge clk); reset_n = 1'b1;
    step();
    reg_read(REG_CTRL, rd);
    check("mid_rst_status", rd, 32'h0);
    reg_read(REG_COUNT, rd);
    check("mid_rst_count", rd, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
